// File: rtl/prbs_checker.sv
// Self-synchronising PRBS-23 (x^23+x^18+1) checker over 4-bit symbols with lock FSM and BER counters.
// Outputs registered, 1 cycle after each valid symbol; no backpressure, any valid_in gap pattern accepted.
module prbs_checker #(
    parameter int LOCK_SYMS   = 16,
    parameter int WIN_SYMS    = 64,
    parameter int LOSS_THRESH = 32,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       bits_in,
    input  logic             valid_in,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [2:0]       err_bits,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int CLEAN_W = $clog2(LOCK_SYMS + 1);
    localparam int WIN_W   = $clog2(WIN_SYMS);
    localparam int WE_W    = $clog2(LOSS_THRESH + 5);

    localparam logic [2:0]         FILL_SYMS = 3'd6;
    localparam logic [CLEAN_W-1:0] LOCK_LAST = CLEAN_W'(LOCK_SYMS - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WIN_SYMS - 1);
    localparam logic [WE_W-1:0]    THRESH_V  = WE_W'(LOSS_THRESH);
    localparam logic [CNT_W:0]     BIT_INC   = (CNT_W + 1)'(4);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t             state;
    logic [22:0]        hist;
    logic [2:0]         fill_cnt;
    logic [CLEAN_W-1:0] clean_cnt;
    logic [WIN_W-1:0]   win_idx;
    logic [WE_W-1:0]    win_err;

    logic [22:0]        hist_nxt;
    logic [3:0]         pred;
    logic [3:0]         diff;
    logic [2:0]         e;
    logic               clean;
    logic [WE_W-1:0]    win_sum;
    logic               drop;
    logic [CNT_W:0]     bit_sum;
    logic [CNT_W:0]     err_sum;
    logic [CNT_W-1:0]   bit_sat;
    logic [CNT_W-1:0]   err_sat;

    // Four serial LFSR steps, MSB first; HUNT feeds received bits back, LOCKED free-runs on predictions.
    always_comb begin
        hist_nxt = hist;
        pred     = '0;
        for (int i = 3; i >= 0; i--) begin
            pred[i]  = hist_nxt[22] ^ hist_nxt[17];
            hist_nxt = {hist_nxt[21:0], (state == LOCKED) ? pred[i] : bits_in[i]};
        end
    end

    always_comb begin
        diff    = bits_in ^ pred;
        e       = 3'(diff[0]) + 3'(diff[1]) + 3'(diff[2]) + 3'(diff[3]);
        clean   = (diff == 4'd0) && (hist != 23'd0);
        win_sum = win_err + WE_W'(e);
        drop    = (win_sum > THRESH_V);
        bit_sum = {1'b0, bit_cnt} + BIT_INC;
        err_sum = {1'b0, err_cnt} + {{(CNT_W - 2){1'b0}}, e};
        bit_sat = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
        err_sat = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            hist      <= '0;
            fill_cnt  <= '0;
            clean_cnt <= '0;
            win_idx   <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
            err_bits  <= '0;
            bit_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (clear) begin
                bit_cnt <= '0;
                err_cnt <= '0;
                win_idx <= '0;
                win_err <= '0;
            end
            if (valid_in) begin
                hist <= hist_nxt;
                case (state)
                    HUNT: begin
                        if (fill_cnt < FILL_SYMS) begin
                            fill_cnt <= fill_cnt + 3'd1;
                        end else if (clean) begin
                            if (clean_cnt == LOCK_LAST) begin
                                state     <= LOCKED;
                                clean_cnt <= '0;
                                win_idx   <= '0;
                                win_err   <= '0;
                            end else begin
                                clean_cnt <= clean_cnt + 1'b1;
                            end
                        end else begin
                            clean_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        err_pulse <= (e != 3'd0);
                        err_bits  <= e;
                        if (!clear) begin
                            bit_cnt <= bit_sat;
                            err_cnt <= err_sat;
                        end
                        if (drop) begin
                            state     <= HUNT;
                            fill_cnt  <= '0;
                            clean_cnt <= '0;
                            win_idx   <= '0;
                            win_err   <= '0;
                        end else if (!clear) begin
                            if (win_idx == WIN_LAST) begin
                                win_idx <= '0;
                                win_err <= '0;
                            end else begin
                                win_idx <= win_idx + 1'b1;
                                win_err <= win_sum;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, error counting, loss/relock, windowing, clear and reset.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  bits_in = 4'h0;
    logic        valid_in = 1'b0;
    logic        clear = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [2:0]  err_bits;
    logic [31:0] bit_cnt;
    logic [31:0] err_cnt;

    int total = 0;
    int bad = 0;

    logic [22:0] g;

    prbs_checker dut (
        .clk       (clk),
        .rst       (rst),
        .bits_in   (bits_in),
        .valid_in  (valid_in),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_bits  (err_bits),
        .bit_cnt   (bit_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Transmit-side generator: g[22] is the next bit out.
    task automatic gen_next(output logic [3:0] s);
        for (int i = 3; i >= 0; i--) begin
            s[i] = g[22];
            g    = {g[21:0], g[22] ^ g[17]};
        end
    endtask

    task automatic step(input logic [3:0] s, input logic v, input logic c);
        bits_in  = s;
        valid_in = v;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(4'h0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Feeds n clean generator symbols and returns the 1-based index after which locked first read 1.
    task automatic run_clean(input int n, output int lock_at);
        logic [3:0] s;
        lock_at = 0;
        for (int i = 1; i <= n; i++) begin
            gen_next(s);
            step(s, 1'b1, 1'b0);
            if (locked && lock_at == 0) lock_at = i;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(4'($urandom), 1'($urandom), 1'b0);
        total++; if (locked !== 1'b0)    begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_err_pulse: got %b want 0", err_pulse); end
        total++; if (err_bits !== 3'd0)  begin bad++; $display("FAIL reset_err_bits: got %0d want 0", err_bits); end
        total++; if (bit_cnt !== 32'd0)  begin bad++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
        total++; if (err_cnt !== 32'd0)  begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_clean_lock();
        int lock_at;
        do_reset();
        g = 23'h7FFFFF;
        run_clean(100, lock_at);
        total++; if (lock_at != 22)     begin bad++; $display("FAIL clean_lock_index: got %0d want 22", lock_at); end
        total++; if (bit_cnt !== 32'd312) begin bad++; $display("FAIL clean_bit_cnt: got %0d want 312", bit_cnt); end
        total++; if (err_cnt !== 32'd0)   begin bad++; $display("FAIL clean_err_cnt: got %0d want 0", err_cnt); end
        for (int i = 0; i < 3; i++) step(4'($urandom), 1'b0, 1'b0);
        total++; if (bit_cnt !== 32'd312) begin bad++; $display("FAIL idle_bit_cnt: got %0d want 312", bit_cnt); end
        total++; if (locked !== 1'b1)     begin bad++; $display("FAIL idle_locked: got %b want 1", locked); end
    endtask

    task automatic test_gap_lock();
        logic [3:0] s;
        int lock_at;
        int pulse_seen;
        do_reset();
        g = 23'h7FFFFF;
        lock_at = 0;
        pulse_seen = 0;
        for (int i = 1; i <= 30; i++) begin
            gen_next(s);
            step(s, 1'b1, 1'b0);
            if (locked && lock_at == 0) lock_at = i;
            step(4'($urandom), 1'b0, 1'b0);
            if (err_pulse) pulse_seen++;
        end
        total++; if (lock_at != 22)  begin bad++; $display("FAIL gap_lock_index: got %0d want 22", lock_at); end
        total++; if (pulse_seen != 0) begin bad++; $display("FAIL gap_err_pulse: got %0d pulses want 0", pulse_seen); end
        total++; if (bit_cnt !== 32'd32) begin bad++; $display("FAIL gap_bit_cnt: got %0d want 32", bit_cnt); end
    endtask

    task automatic test_single_error();
        logic [3:0] s;
        int lock_at;
        do_reset();
        g = 23'h7FFFFF;
        run_clean(39, lock_at);
        gen_next(s);
        step(s ^ 4'b0100, 1'b1, 1'b0);
        total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL single_err_pulse: got %b want 1", err_pulse); end
        total++; if (err_bits !== 3'd1)  begin bad++; $display("FAIL single_err_bits: got %0d want 1", err_bits); end
        total++; if (err_cnt !== 32'd1)  begin bad++; $display("FAIL single_err_cnt: got %0d want 1", err_cnt); end
        gen_next(s);
        step(s, 1'b1, 1'b0);
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL single_pulse_width: got %b want 0", err_pulse); end
        total++; if (err_bits !== 3'd0)  begin bad++; $display("FAIL single_err_bits_next: got %0d want 0", err_bits); end
        run_clean(19, lock_at);
        total++; if (locked !== 1'b1)     begin bad++; $display("FAIL single_locked: got %b want 1", locked); end
        total++; if (err_cnt !== 32'd1)   begin bad++; $display("FAIL single_err_cnt_end: got %0d want 1", err_cnt); end
        total++; if (bit_cnt !== 32'd152) begin bad++; $display("FAIL single_bit_cnt_end: got %0d want 152", bit_cnt); end
    endtask

    task automatic test_loss_relock();
        logic [3:0] s;
        int lock_at;
        int early_drop;
        do_reset();
        g = 23'h7FFFFF;
        run_clean(22, lock_at);
        early_drop = 0;
        for (int i = 1; i <= 9; i++) begin
            gen_next(s);
            step(~s, 1'b1, 1'b0);
            if (i < 9 && !locked) early_drop++;
        end
        total++; if (early_drop != 0)    begin bad++; $display("FAIL loss_early_drop: got %0d want 0", early_drop); end
        total++; if (locked !== 1'b0)    begin bad++; $display("FAIL loss_locked: got %b want 0", locked); end
        total++; if (err_cnt !== 32'd36) begin bad++; $display("FAIL loss_err_cnt: got %0d want 36", err_cnt); end
        total++; if (bit_cnt !== 32'd36) begin bad++; $display("FAIL loss_bit_cnt: got %0d want 36", bit_cnt); end
        run_clean(40, lock_at);
        total++; if (lock_at != 22)      begin bad++; $display("FAIL relock_index: got %0d want 22", lock_at); end
        total++; if (err_cnt !== 32'd36) begin bad++; $display("FAIL relock_err_cnt: got %0d want 36", err_cnt); end
        total++; if (bit_cnt !== 32'd108) begin bad++; $display("FAIL relock_bit_cnt: got %0d want 108", bit_cnt); end
    endtask

    task automatic test_window();
        logic [3:0] s;
        int lock_at;
        do_reset();
        g = 23'h7FFFFF;
        run_clean(78, lock_at);
        for (int i = 79; i <= 86; i++) begin
            gen_next(s);
            step(~s, 1'b1, 1'b0);
        end
        total++; if (locked !== 1'b1)    begin bad++; $display("FAIL window_at_thresh_locked: got %b want 1", locked); end
        total++; if (err_cnt !== 32'd32) begin bad++; $display("FAIL window_err_cnt: got %0d want 32", err_cnt); end
        gen_next(s);
        step(~s, 1'b1, 1'b0);
        total++; if (locked !== 1'b1)    begin bad++; $display("FAIL window_rollover_locked: got %b want 1", locked); end
        total++; if (err_cnt !== 32'd36) begin bad++; $display("FAIL window_rollover_err_cnt: got %0d want 36", err_cnt); end
        total++; if (err_bits !== 3'd4)  begin bad++; $display("FAIL window_err_bits: got %0d want 4", err_bits); end
    endtask

    task automatic test_all_zero();
        int ever_locked;
        do_reset();
        ever_locked = 0;
        for (int i = 0; i < 500; i++) begin
            step(4'h0, 1'b1, 1'b0);
            if (locked) ever_locked++;
        end
        total++; if (ever_locked != 0)  begin bad++; $display("FAIL zero_locked: got %0d locked cycles want 0", ever_locked); end
        total++; if (bit_cnt !== 32'd0) begin bad++; $display("FAIL zero_bit_cnt: got %0d want 0", bit_cnt); end
        total++; if (err_cnt !== 32'd0) begin bad++; $display("FAIL zero_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_clear();
        logic [3:0] s;
        int lock_at;
        do_reset();
        g = 23'h7FFFFF;
        run_clean(30, lock_at);
        total++; if (bit_cnt !== 32'd32) begin bad++; $display("FAIL clear_pre_bit_cnt: got %0d want 32", bit_cnt); end
        gen_next(s);
        step(s ^ 4'b0001, 1'b1, 1'b1);
        total++; if (bit_cnt !== 32'd0) begin bad++; $display("FAIL clear_bit_cnt: got %0d want 0", bit_cnt); end
        total++; if (err_cnt !== 32'd0) begin bad++; $display("FAIL clear_err_cnt: got %0d want 0", err_cnt); end
        total++; if (locked !== 1'b1)   begin bad++; $display("FAIL clear_locked: got %b want 1", locked); end
        gen_next(s);
        step(s, 1'b1, 1'b0);
        total++; if (bit_cnt !== 32'd4) begin bad++; $display("FAIL clear_next_bit_cnt: got %0d want 4", bit_cnt); end
        total++; if (err_cnt !== 32'd0) begin bad++; $display("FAIL clear_next_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_mid_reset();
        int lock_at;
        rst = 1'b1;
        step(4'hA, 1'b1, 1'b0);
        rst = 1'b0;
        total++; if (locked !== 1'b0)   begin bad++; $display("FAIL midrst_locked: got %b want 0", locked); end
        total++; if (bit_cnt !== 32'd0) begin bad++; $display("FAIL midrst_bit_cnt: got %0d want 0", bit_cnt); end
        g = 23'h5A3C1F;
        run_clean(30, lock_at);
        total++; if (lock_at != 22)      begin bad++; $display("FAIL seed_lock_index: got %0d want 22", lock_at); end
        total++; if (bit_cnt !== 32'd32) begin bad++; $display("FAIL seed_bit_cnt: got %0d want 32", bit_cnt); end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_gap_lock();
        test_single_error();
        test_loss_relock();
        test_window();
        test_all_zero();
        test_clear();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Receive-side PRBS-23 checker for the G-DSP Engine loopback/BER path. Consumes 4-bit demapped symbols, self-synchronises a local x^23 + x^18 + 1 sequence model to the incoming stream, and once locked free-runs that model to count bit errors without error multiplication. Sits directly downstream of the QAM demapper. It is the counterpart of the transmit PRBS-23 bit generator: it accepts that generator's stream with any seed and any phase.

## Interface
- LOCK_SYMS, 16: consecutive error-free symbols required in HUNT to declare lock.
- WIN_SYMS, 64: length, in locked symbols, of the tumbling loss-of-lock window.
- LOSS_THRESH, 32: lock is dropped when window bit errors exceed this value.
- CNT_W, 32: width of the bit and error counters.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- bits_in  in  BITS_PER_SYM (4)  received symbol bits; bit[3] is first in time, bit[0] last.
- valid_in  in  1  bits_in is valid this cycle; any gap pattern is allowed.
- clear  in  1  synchronous clear of bit_cnt, err_cnt and the window state; lock state is unaffected.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle strobe: the last locked symbol had at least one bit error.
- err_bits  out  3  number of errored bits in the last locked symbol (0..4).
- bit_cnt  out  CNT_W  bits compared while locked; saturates at all-ones.
- err_cnt  out  CNT_W  errored bits while locked; saturates at all-ones.

## Operation
- Sequence model: b[n] = b[n-23] ^ b[n-18]. A 23-bit history register holds the last 23 bits, newest in the LSB.
- Each valid symbol is processed as 4 unrolled serial steps, in order bit[3], bit[2], bit[1], bit[0]:
  - Predict p = h[22] ^ h[17].
  - Shift the history left.
- History update source depends on state:
  - HUNT: the history shifts in received bits (self-synchronising).
  - LOCKED: the history shifts in predicted bits (free-run).
- FSM:
  - HUNT, fill phase: the first 6 valid symbols after entry only load the history (24 bits ≥ 23). No comparison is made.
  - HUNT, evaluation: each subsequent symbol is clean when all 4 predictions match and the history before the symbol is non-zero. A clean symbol increments clean_cnt. Any other symbol clears clean_cnt to 0.
  - HUNT → LOCKED: when clean_cnt reaches LOCK_SYMS. The history at that moment seeds the free-running model.
  - LOCKED, per symbol:
    - e = popcount(bits_in ^ predicted), 0..4.
    - bit_cnt += 4; err_cnt += e (both saturating).
    - win_err += e.
    - win_idx increments. At win_idx = WIN_SYMS-1, win_idx and win_err reset to 0 after the check.
  - LOCKED → HUNT: when win_err + e > LOSS_THRESH. On this transition fill_cnt, clean_cnt, win_idx and win_err are set to 0. The history is reloaded from received bits during the fill phase.
- Counters only advance in LOCKED. Symbols received in HUNT never touch bit_cnt or err_cnt.
- clear together with valid_in: clear wins. Counters and window go to 0 and that symbol's contribution is discarded. The history and FSM still advance normally.
- An all-zero history never counts as clean, so an all-zero or stuck-at-0 input never locks.

## Timing
- All outputs are registered. Latency is 1 cycle from the valid_in edge to the locked, err_pulse, err_bits, bit_cnt and err_cnt update.
- err_pulse is high for exactly the one cycle after an errored locked symbol, otherwise 0. err_bits holds its value until the next locked symbol.
- locked rises the cycle after the valid that completes the LOCK_SYMS-th clean symbol. It falls the cycle after the symbol that breaks the threshold.
- Cycles with valid_in = 0 change no state; err_pulse returns to 0.
- Reset: state HUNT; history = 0; fill_cnt, clean_cnt, win_idx and win_err = 0; all outputs 0.
- rst mid-operation behaves identically to reset from power-up.

## Test plan
- Reset: hold rst for 3 cycles with random valid_in/bits_in → locked = 0, err_pulse = 0, err_bits = 0, bit_cnt = 0, err_cnt = 0.
- Clean lock: feed the generator stream with seed 23'h7FFFFF (symbols 4'hF ×5, then 4'hE, ...) continuously:
  - locked rises the cycle after symbol 22.
  - After symbol 100: bit_cnt = 312, err_cnt = 0.
  - Repeat with valid_in every other cycle → same symbol index at lock.
- Single error: after lock, flip bit[2] of symbol 40:
  - err_pulse high for 1 cycle, err_bits = 1, err_cnt = 1.
  - locked stays 1 and no further errors accrue.
- Loss of lock: after lock, invert 9 consecutive symbols → locked falls the cycle after the 9th (win_err = 36 > 32) and err_cnt = 36. Restore good data → relock 22 symbols later with the counters preserved.
- All-zero input: 500 symbols of 4'h0 → locked stays 0 and both counters stay 0.
- Clear: assert clear together with an errored locked symbol → bit_cnt = 0 and err_cnt = 0 next cycle. The next clean symbol gives bit_cnt = 4.
